dm_ctrl: RTL

Parametrised data-memory controller for the multi-cycle CPU, the successor to the flat word-only data memory. It adds a valid/ready request handshake, configurable wait states, and byte, halfword and word loads/stores with sign or zero extension. It also flags misaligned or reserved-size accesses. It sits between the CPU's MEM-stage control FSM and an internal byte-enabled RAM.

---
 rtl/dm_pkg.sv | 57 +++++
 rtl/dm_bram.sv | 25 ++
 rtl/dm_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the data-memory controller.
// Holds the size and state encodings plus byte-enable, store-alignment and load-extension helpers.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data onto every lane; byte enables pick the live ones.
    function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{wdata[7:0]}};
            SZ_HALF: r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_bram.sv
// Byte-enabled word array with combinational read and synchronous write.
// Contents are never reset.
module dm_bram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: request handshake, wait states, sized loads/stores
// with extension, and misalignment/reserved-size error reporting.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle strobe with no backpressure.

    localparam int         AW        = DEPTH_LOG2 + 2;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e         state_q, state_d;
    logic [3:0]     wait_q, wait_d;
    logic           write_q, write_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic           accept;
    logic           bad_req;
    logic [3:0]     bram_we;
    logic [31:0]    bram_rdata;

    // Address bits above the array span alias onto it by design.
    generate
        if (ADDR_W > AW) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:AW];
        end
    endgenerate

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign bad_req    = (req_size == SZ_RSVD)
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        bram_we = 4'b0000;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    if (bad_req) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (WAIT_STATES > 0) begin
                        wait_d  = WAIT_INIT;
                        state_d = WAIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ACCESS: begin
                err_d   = 1'b0;
                state_d = RESP;
                if (write_q) begin
                    bram_we = byte_en(size_q, addr_q[1:0]);
                    rdata_d = 32'h0;
                end else begin
                    rdata_d = extend_load(bram_rdata, size_q, addr_q[1:0], uns_q);
                end
            end
            RESP: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    dm_bram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bram (
        .clock (clock),
        .we    (bram_we),
        .addr  (addr_q[AW-1:2]),
        .wdata (align_wdata(size_q, wdata_q)),
        .rdata (bram_rdata)
    );

endmodule
